multicycle_control: RTL and testbench

- Moore FSM that sequences a multicycle MIPS datapath around one shared ALU and one unified instruction/data memory.
- Replaces the single-cycle Control decoder. Drives PC, IR, memory, register file and ALU mux selects state by state.
- Stretches memory states on a ready handshake and flags memory timeouts and illegal opcodes.

---
 rtl/multicycle_control.sv | 236 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// +--------------------------------------------------------------------------+
// | Module  : multicycle_control                                             |
// | Brief   : Moore control FSM for a multicycle MIPS datapath sharing one   |
// |           ALU and one unified instruction/data memory. Memory states     |
// |           stretch on mem_ready and time out into a sticky error.         |
// | Option  : define MC_PERF_COUNT_EN to add cycle_count / instr_count.      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDest,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ALUOp1,
  output logic               ALUOp2,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic               mem_error,
  output logic [STATE_W-1:0] state_dbg
`ifdef MC_PERF_COUNT_EN
  ,
  output logic [31:0]        cycle_count,
  output logic [31:0]        instr_count
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = STATE_W'(0),
    FETCH     = STATE_W'(1),
    DECODE    = STATE_W'(2),
    MEM_ADDR  = STATE_W'(3),
    MEM_READ  = STATE_W'(4),
    MEM_WB    = STATE_W'(5),
    MEM_WRITE = STATE_W'(6),
    EXECUTE   = STATE_W'(7),
    R_WB      = STATE_W'(8),
    BRANCH    = STATE_W'(9),
    JUMP      = STATE_W'(10),
    HALT      = STATE_W'(11)
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             is_mem;
  logic             timeout;
  logic             set_illegal;
  logic             set_timeout;

  // The zero flag acts in the datapath through PCWriteCond, never in the FSM.
  logic unused_zero;
  assign unused_zero = zero;

  assign state_dbg = state;

  // State register, memory wait counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      illegal_op <= 1'b0;
      mem_error  <= 1'b0;
    end else begin
      state <= state_next;
      // Any state change starts a fresh wait window for the next memory state.
      if (state_next != state)
        wait_cnt <= '0;
      else if (is_mem && !mem_ready && (wait_cnt != '1))
        wait_cnt <= wait_cnt + 1'b1;
      if (set_illegal)
        illegal_op <= 1'b1;
      if (set_timeout)
        mem_error <= 1'b1;
    end
  end

  // Next-state and Moore control decode; FETCH write strobes are qualified by mem_ready.
  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDest     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp1      = 1'b0;
    ALUOp2      = 1'b0;
    PCSource    = 2'b00;
    is_mem      = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
    // The last permitted wait cycle: counter will hit MEM_TIMEOUT on this edge.
    timeout     = is_mem && !mem_ready && (wait_cnt >= CNT_W'(MEM_TIMEOUT - 1));

    case (state)
      IDLE: begin
        if (run)
          state_next = FETCH;
      end
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = DECODE;
        end else if (timeout) begin
          set_timeout = 1'b1;
          state_next  = HALT;
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_RTYP:      state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          default: begin
            set_illegal = 1'b1;
            state_next  = HALT;
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)
          state_next = MEM_WB;
        else if (timeout) begin
          set_timeout = 1'b1;
          state_next  = HALT;
        end
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        state_next = FETCH;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready)
          state_next = FETCH;
        else if (timeout) begin
          set_timeout = 1'b1;
          state_next  = HALT;
        end
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUOp1     = 1'b1;
        state_next = R_WB;
      end
      R_WB: begin
        RegWrite   = 1'b1;
        RegDest    = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp2      = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_next  = FETCH;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        state_next = FETCH;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef MC_PERF_COUNT_EN
  // Active-cycle and retired-instruction counters, free-running with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if ((state != IDLE) && (state != HALT))
        cycle_count <= cycle_count + 32'd1;
      if ((state_next == FETCH) &&
          ((state == MEM_WB) || (state == MEM_WRITE) || (state == R_WB) ||
           (state == BRANCH) || (state == JUMP)))
        instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_multicycle_control                                          |
// | Brief   : Scoreboard bench for multicycle_control. Stimulus pushes the   |
// |           hand-computed per-cycle state/control word; a monitor pops and |
// |           compares at the falling edge. MC_PERF_COUNT_EN adds counters.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_control;

  // Control word: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,
  //                RegDest,RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp1,ALUOp2,PCSource[1:0]}
  localparam logic [15:0] C_ZERO   = 16'h0000;
  localparam logic [15:0] C_FWAIT  = 16'h1010;
  localparam logic [15:0] C_FRDY   = 16'h9410;
  localparam logic [15:0] C_DEC    = 16'h0030;
  localparam logic [15:0] C_MADDR  = 16'h0060;
  localparam logic [15:0] C_MREAD  = 16'h3000;
  localparam logic [15:0] C_MWB    = 16'h0280;
  localparam logic [15:0] C_MWRITE = 16'h2800;
  localparam logic [15:0] C_EXEC   = 16'h0048;
  localparam logic [15:0] C_RWB    = 16'h0180;
  localparam logic [15:0] C_BR     = 16'h4045;
  localparam logic [15:0] C_JMP    = 16'h8002;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemToReg, RegDest, RegWrite, ALUSrcA, ALUOp1, ALUOp2;
  logic [1:0]  ALUSrcB, PCSource;
  logic        illegal_op, mem_error;
  logic [3:0]  state_dbg;
`ifdef MC_PERF_COUNT_EN
  logic [31:0] cycle_count, instr_count;
`endif
  logic [15:0] ctrl;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] c;
    logic        ill;
    logic        err;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                 RegDest, RegWrite, ALUSrcA, ALUSrcB, ALUOp1, ALUOp2, PCSource};

  multicycle_control #(.MEM_TIMEOUT(15), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDest(RegDest), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp1(ALUOp1), .ALUOp2(ALUOp2),
    .PCSource(PCSource), .illegal_op(illegal_op), .mem_error(mem_error),
    .state_dbg(state_dbg)
`ifdef MC_PERF_COUNT_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (state_dbg !== e.st || ctrl !== e.c || illegal_op !== e.ill || mem_error !== e.err) begin
        failed++;
        $display("FAIL %s: got st=%0d ctrl=%h ill=%b err=%b, expected st=%0d ctrl=%h ill=%b err=%b",
                 e.nm, state_dbg, ctrl, illegal_op, mem_error, e.st, e.c, e.ill, e.err);
      end
    end
  end

  // Drive inputs for one cycle and record what the DUT must show during it.
  task automatic step(input logic r, input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input logic [15:0] c,
                      input logic ill, input logic err, input string nm);
    exp_t e;
    run = r; opcode = op; mem_ready = mr;
    e.st = st; e.c = c; e.ill = ill; e.err = err; e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, RT, 0, 4'd0, C_ZERO, 0, 0, "reset_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = RT; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 5; i++) step(0, LW, 1, 4'd0, C_ZERO, 0, 0, "idle_run0");
    step(1, LW, 1, 4'd0, C_ZERO, 0, 0, "idle_go");

    // lw with run dropped mid-instruction: 1,2,3,4,5
    step(0, LW, 1, 4'd1, C_FRDY,  0, 0, "lw_fetch");
    step(0, LW, 1, 4'd2, C_DEC,   0, 0, "lw_decode");
    step(0, LW, 1, 4'd3, C_MADDR, 0, 0, "lw_maddr");
    step(0, LW, 1, 4'd4, C_MREAD, 0, 0, "lw_mread");
    step(0, LW, 1, 4'd5, C_MWB,   0, 0, "lw_mwb");
    // sw: 1,2,3,6
    step(0, SW, 1, 4'd1, C_FRDY,   0, 0, "sw_fetch");
    step(0, SW, 1, 4'd2, C_DEC,    0, 0, "sw_decode");
    step(0, SW, 1, 4'd3, C_MADDR,  0, 0, "sw_maddr");
    step(0, SW, 1, 4'd6, C_MWRITE, 0, 0, "sw_mwrite");
    // R-type: 1,2,7,8
    step(0, RT, 1, 4'd1, C_FRDY, 0, 0, "r_fetch");
    step(0, RT, 1, 4'd2, C_DEC,  0, 0, "r_decode");
    step(0, RT, 1, 4'd7, C_EXEC, 0, 0, "r_exec");
    step(0, RT, 1, 4'd8, C_RWB,  0, 0, "r_wb");
    // beq: 1,2,9
    step(0, BEQ, 1, 4'd1, C_FRDY, 0, 0, "beq_fetch");
    step(0, BEQ, 1, 4'd2, C_DEC,  0, 0, "beq_decode");
    step(0, BEQ, 1, 4'd9, C_BR,   0, 0, "beq_branch");
    // j: 1,2,10
    step(0, JMP, 1, 4'd1,  C_FRDY, 0, 0, "j_fetch");
    step(0, JMP, 1, 4'd2,  C_DEC,  0, 0, "j_decode");
    step(0, JMP, 1, 4'd10, C_JMP,  0, 0, "j_jump");
    // Fetch stretched 3 cycles, then R-type completes
    for (int i = 0; i < 3; i++) step(0, RT, 0, 4'd1, C_FWAIT, 0, 0, "fetch_wait");
    step(0, RT, 1, 4'd1, C_FRDY, 0, 0, "fetch_wait_done");
    step(0, RT, 1, 4'd2, C_DEC,  0, 0, "fw_decode");
    step(0, RT, 1, 4'd7, C_EXEC, 0, 0, "fw_exec");
    step(0, RT, 1, 4'd8, C_RWB,  0, 0, "fw_rwb");
    // lw whose ready lands in the last permitted wait cycle: no error
    step(0, LW, 1, 4'd1, C_FRDY,  0, 0, "lwb_fetch");
    step(0, LW, 1, 4'd2, C_DEC,   0, 0, "lwb_decode");
    step(0, LW, 1, 4'd3, C_MADDR, 0, 0, "lwb_maddr");
    for (int i = 0; i < 14; i++) step(0, LW, 0, 4'd4, C_MREAD, 0, 0, "lwb_wait");
    step(0, LW, 1, 4'd4, C_MREAD, 0, 0, "lwb_ready_wins");
    step(0, LW, 1, 4'd5, C_MWB,   0, 0, "lwb_mwb");
    // sw with memory stuck: 15 wait cycles then HALT with mem_error
    step(0, SW, 1, 4'd1, C_FRDY,  0, 0, "swt_fetch");
    step(0, SW, 1, 4'd2, C_DEC,   0, 0, "swt_decode");
    step(0, SW, 1, 4'd3, C_MADDR, 0, 0, "swt_maddr");
    for (int i = 0; i < 15; i++) step(0, SW, 0, 4'd6, C_MWRITE, 0, 0, "swt_wait");
    step(1, SW, 1, 4'd11, C_ZERO, 0, 1, "swt_halt");
    step(1, SW, 1, 4'd11, C_ZERO, 0, 1, "swt_halt_sticky");
    // Reset clears mem_error
    do_reset();
    // Illegal opcode -> HALT with illegal_op
    step(1, BAD, 1, 4'd0,  C_ZERO, 0, 0, "ill_idle");
    step(0, BAD, 1, 4'd1,  C_FRDY, 0, 0, "ill_fetch");
    step(0, BAD, 1, 4'd2,  C_DEC,  0, 0, "ill_decode");
    step(0, BAD, 1, 4'd11, C_ZERO, 1, 0, "ill_halt");
    step(1, RT,  1, 4'd11, C_ZERO, 1, 0, "ill_halt_sticky");
    // Async reset in the middle of a fetch wait drops strobes at once
    do_reset();
    step(1, RT, 0, 4'd0, C_ZERO,  0, 0, "ar_idle");
    step(0, RT, 0, 4'd1, C_FWAIT, 0, 0, "ar_wait");
    step(0, RT, 0, 4'd1, C_FWAIT, 0, 0, "ar_wait");
    do_reset();
    // R-type from reset, for the optional counters
    step(1, RT, 1, 4'd0, C_ZERO, 0, 0, "pc_idle");
    step(0, RT, 1, 4'd1, C_FRDY, 0, 0, "pc_fetch");
    step(0, RT, 1, 4'd2, C_DEC,  0, 0, "pc_decode");
    step(0, RT, 1, 4'd7, C_EXEC, 0, 0, "pc_exec");
    step(0, RT, 1, 4'd8, C_RWB,  0, 0, "pc_rwb");
`ifdef MC_PERF_COUNT_EN
    tests++;
    if (instr_count !== 32'd1 || cycle_count !== 32'd4) begin
      failed++;
      $display("FAIL perf_counters: got instr=%0d cycle=%0d, expected instr=1 cycle=4",
               instr_count, cycle_count);
    end
`endif
    step(0, RT, 1, 4'd1, C_FRDY, 0, 0, "pc_fetch2");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failed++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
